// File: rtl/hazard_ctrl.sv
// Stall/bubble scheduler for the 5-stage pipeline: load-use, EX redirect,
// data-memory wait and sync drain, plus a memory-wait timeout and stall counter.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_to_reg,
  input  logic [4:0]       ex_reg_dst_id,
  input  logic             mem_mem_to_reg,
  input  logic [4:0]       mem_reg_dst_id,
  input  logic             ex_redirect,
  input  logic             ex_is_sync,
  input  logic             mem_is_ls,
  input  logic             wb_is_ls,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_bubble,
  output logic             id_ex_stall,
  output logic             id_ex_bubble,
  output logic             ex_mem_stall,
  output logic             ex_mem_bubble,
  output logic             mem_wb_stall,
  output logic             mem_wb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {StRun, StMemWait, StSyncDrain} state_e;

  state_e           r_state;
  logic [WaitW-1:0] r_wait_cnt;
  logic             r_mem_timeout;
  logic [CNT_W-1:0] r_stall_cycles;

  logic w_mem_wait, w_sync_hold, w_match_ex, w_match_mem, w_load_use;

  assign w_mem_wait  = mem_req & ~mem_ready;
  assign w_sync_hold = ex_is_sync & (mem_is_ls | wb_is_ls);
  assign w_match_ex  = (id_uses_rs && (id_rs == ex_reg_dst_id)) ||
                       (id_uses_rt && (id_rt == ex_reg_dst_id));
  assign w_match_mem = (id_uses_rs && (id_rs == mem_reg_dst_id)) ||
                       (id_uses_rt && (id_rt == mem_reg_dst_id));
  assign w_load_use  = (ex_mem_to_reg && (ex_reg_dst_id != 5'd0) && w_match_ex) ||
                       (mem_mem_to_reg && (mem_reg_dst_id != 5'd0) && w_match_mem);

  // Prioritised stall/bubble decode; everything quiet while in reset.
  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_bubble  = 1'b0;
    id_ex_stall   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_stall  = 1'b0;
    ex_mem_bubble = 1'b0;
    mem_wb_stall  = 1'b0;
    mem_wb_bubble = 1'b0;
    if (!rst) begin
      if (w_mem_wait) begin
        pc_stall      = 1'b1;
        if_id_stall   = 1'b1;
        id_ex_stall   = 1'b1;
        ex_mem_stall  = 1'b1;
        mem_wb_bubble = 1'b1;
      end else if (w_sync_hold) begin
        pc_stall      = 1'b1;
        if_id_stall   = 1'b1;
        id_ex_stall   = 1'b1;
        ex_mem_bubble = 1'b1;
      end else if (ex_redirect) begin
        // PC keeps moving so the redirect target gets loaded.
        if_id_bubble  = 1'b1;
        id_ex_bubble  = 1'b1;
      end else if (w_load_use) begin
        pc_stall      = 1'b1;
        if_id_stall   = 1'b1;
        id_ex_bubble  = 1'b1;
      end
    end
  end

  // State FSM tracking which hold condition the pipeline is in.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state <= StRun;
    end else begin
      unique case (r_state)
        StRun: begin
          if (w_mem_wait)       r_state <= StMemWait;
          else if (w_sync_hold) r_state <= StSyncDrain;
        end
        StMemWait: begin
          if (!w_mem_wait) r_state <= w_sync_hold ? StSyncDrain : StRun;
        end
        StSyncDrain: begin
          if (w_mem_wait)        r_state <= StMemWait;
          else if (!w_sync_hold) r_state <= StRun;
        end
        default: r_state <= StRun;
      endcase
    end
  end

  // Consecutive memory-wait counter and sticky timeout flag.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else if (w_mem_wait) begin
      if (r_wait_cnt == WaitLast) r_mem_timeout <= 1'b1;
      else                        r_wait_cnt    <= r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Saturating count of cycles with the PC held.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (pc_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign mem_timeout  = r_mem_timeout;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes expected responses, a
// negedge monitor pops and compares against the DUT.
module tb_hazard_ctrl;

  localparam int unsigned MT = 4;
  localparam int unsigned CW = 8;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic          rst;
  logic [4:0]    id_rs, id_rt, ex_reg_dst_id, mem_reg_dst_id;
  logic          id_uses_rs, id_uses_rt, ex_mem_to_reg, mem_mem_to_reg;
  logic          ex_redirect, ex_is_sync, mem_is_ls, wb_is_ls, mem_req, mem_ready;
  logic          pc_stall, if_id_stall, if_id_bubble, id_ex_stall, id_ex_bubble;
  logic          ex_mem_stall, ex_mem_bubble, mem_wb_stall, mem_wb_bubble;
  logic          mem_timeout;
  logic [CW-1:0] stall_cycles;

  hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_dst_id(ex_reg_dst_id),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_reg_dst_id(mem_reg_dst_id),
    .ex_redirect(ex_redirect), .ex_is_sync(ex_is_sync), .mem_is_ls(mem_is_ls),
    .wb_is_ls(wb_is_ls), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_bubble(if_id_bubble),
    .id_ex_stall(id_ex_stall), .id_ex_bubble(id_ex_bubble),
    .ex_mem_stall(ex_mem_stall), .ex_mem_bubble(ex_mem_bubble),
    .mem_wb_stall(mem_wb_stall), .mem_wb_bubble(mem_wb_bubble),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  // Index 0 = PC, 1 = if_id, 2 = id_ex, 3 = ex_mem, 4 = mem_wb.
  typedef struct {
    logic [4:0]    stl;
    logic [4:0]    bub;
    logic          to;
    logic [CW-1:0] sc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state.
  int m_run = 0;
  bit m_to  = 0;
  int m_sc  = 0;

  function automatic bit reads(input logic [4:0] r);
    return (r != 0) && ((id_uses_rs && id_rs == r) || (id_uses_rt && id_rt == r));
  endfunction

  // Compute expected response of the current inputs, queue it, advance model one edge.
  task automatic issue();
    exp_t e;
    int   freeze;
    bit   mw, redir;
    mw     = mem_req && !mem_ready;
    redir  = 0;
    freeze = 0;
    if (!rst) begin
      if (mw)                                         freeze = 4;
      else if (ex_is_sync && (mem_is_ls || wb_is_ls)) freeze = 3;
      else if (ex_redirect)                           redir  = 1;
      else if ((ex_mem_to_reg && reads(ex_reg_dst_id)) ||
               (mem_mem_to_reg && reads(mem_reg_dst_id))) freeze = 2;
    end
    e.stl = '0;
    e.bub = '0;
    for (int i = 0; i < 5; i++) if (i < freeze) e.stl[i] = 1'b1;
    if (freeze != 0) e.bub[freeze] = 1'b1;
    if (redir) e.bub = 5'b00110;
    e.to = m_to;
    e.sc = CW'(m_sc);
    exp_q.push_back(e);
    if (rst) begin
      m_run = 0; m_to = 0; m_sc = 0;
    end else begin
      m_run = mw ? m_run + 1 : 0;
      if (m_run >= MT) m_to = 1;
      if (e.stl[0] && m_sc < (1 << CW) - 1) m_sc++;
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clr_in();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    ex_mem_to_reg = 0; ex_reg_dst_id = 0; mem_mem_to_reg = 0; mem_reg_dst_id = 0;
    ex_redirect = 0; ex_is_sync = 0; mem_is_ls = 0; wb_is_ls = 0;
    mem_req = 0; mem_ready = 0;
  endtask

  // Monitor: outputs are combinational, compare mid-cycle on the falling edge.
  always @(negedge sys_clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      logic [4:0] s, b;
      e = exp_q.pop_front();
      s = {mem_wb_stall, ex_mem_stall, id_ex_stall, if_id_stall, pc_stall};
      b = {mem_wb_bubble, ex_mem_bubble, id_ex_bubble, if_id_bubble, 1'b0};
      checks += 3;
      if (s !== e.stl) begin
        errors++;
        $display("FAIL stall t=%0t got=%b want=%b", $time, s, e.stl);
      end
      if (b !== e.bub) begin
        errors++;
        $display("FAIL bubble t=%0t got=%b want=%b", $time, b, e.bub);
      end
      if (mem_timeout !== e.to || stall_cycles !== e.sc) begin
        errors++;
        $display("FAIL counters t=%0t got to=%b sc=%0d want to=%b sc=%0d",
                 $time, mem_timeout, stall_cycles, e.to, e.sc);
      end
    end
  end

  initial begin
    clr_in();
    rst = 1;
    @(posedge sys_clk);
    #1;
    // Reset forces outputs low even with every hazard asserted.
    mem_req = 1; ex_is_sync = 1; wb_is_ls = 1; ex_redirect = 1;
    issue();
    issue();
    clr_in();
    rst = 0;
    issue();
    // T1 load-use on rs; T2 dst 0 and unused rs.
    ex_mem_to_reg = 1; ex_reg_dst_id = 8; id_rs = 8; id_uses_rs = 1;
    issue();
    ex_reg_dst_id = 0; id_rs = 0;
    issue();
    ex_reg_dst_id = 8; id_rs = 8; id_uses_rs = 0;
    issue();
    // Load in MEM matching rt.
    clr_in(); mem_mem_to_reg = 1; mem_reg_dst_id = 3; id_rt = 3; id_uses_rt = 1;
    issue();
    // T3 redirect beats load-use.
    clr_in(); ex_mem_to_reg = 1; ex_reg_dst_id = 8; id_rs = 8; id_uses_rs = 1; ex_redirect = 1;
    issue();
    // T4 three wait cycles with redirect held, then ready.
    clr_in(); ex_redirect = 1; mem_req = 1;
    repeat (3) issue();
    mem_ready = 1;
    issue();
    // T5 sync drain for two cycles.
    clr_in(); ex_is_sync = 1; wb_is_ls = 1;
    repeat (2) issue();
    clr_in();
    issue();
    // T6 endless wait: timeout after the 4th cycle, sticky, then cleared by reset.
    mem_req = 1;
    repeat (7) issue();
    clr_in();
    repeat (2) issue();
    rst = 1; mem_req = 1;
    issue();
    rst = 0; clr_in();
    issue();
    // Random traffic; small register range to provoke matches.
    repeat (3000) begin
      rst            = ($urandom_range(0, 79) == 0);
      id_rs          = 5'($urandom_range(0, 3));
      id_rt          = 5'($urandom_range(0, 3));
      id_uses_rs     = 1'($urandom);
      id_uses_rt     = 1'($urandom);
      ex_mem_to_reg  = 1'($urandom);
      ex_reg_dst_id  = 5'($urandom_range(0, 3));
      mem_mem_to_reg = 1'($urandom);
      mem_reg_dst_id = 5'($urandom_range(0, 3));
      ex_redirect    = ($urandom_range(0, 4) == 0);
      ex_is_sync     = ($urandom_range(0, 5) == 0);
      mem_is_ls      = ($urandom_range(0, 2) == 0);
      wb_is_ls       = ($urandom_range(0, 2) == 0);
      mem_req        = ($urandom_range(0, 2) == 0);
      mem_ready      = ($urandom_range(0, 3) != 0);
      issue();
    end
    clr_in();
    @(negedge sys_clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
